mandel_frame_done_collector: RTL and testbench

- Upstream status stage for the 1-bit HPS input PIO.
- Launches all Mandelbrot solver cores on an HPS start request and collects each core's done indication.
- Drives a single level flag, all_done, which the input PIO samples and returns to software as bit 0 of its readdata.
- Also provides a frame cycle count, a timeout flag and a busy indication for debug and performance PIOs.

---
 rtl/mandel_frame_done_collector.sv | 99 +++++++++
 tb/tb_mandel_frame_done_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mandel_frame_done_collector.sv
// Launches all Mandelbrot solver cores on a rising start edge and collects their done edges.
// all_done is the level the input PIO returns to software; frame_cycles, timed_out and busy feed debug PIOs.
module mandel_frame_done_collector #(
  parameter int NUM_SOLVERS    = 8,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [NUM_SOLVERS-1:0] solver_done,
  output logic                   solver_start,
  output logic                   busy,
  output logic                   all_done,
  output logic                   timed_out,
  output logic [CNT_W-1:0]       frame_cycles
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t                 state, state_n;
  logic                   start_d;
  logic [NUM_SOLVERS-1:0] done_d;
  logic [NUM_SOLVERS-1:0] sticky, sticky_n, sticky_next;
  logic [CNT_W-1:0]       cycles_n, cycles_inc;
  logic                   timed_out_n;
  logic                   start_rise;
  logic [NUM_SOLVERS-1:0] done_rise;

  assign start_rise  = start & ~start_d;
  assign done_rise   = solver_done & ~done_d;
  // Edges arriving in the same cycle count toward completion of that cycle.
  assign sticky_next = sticky | done_rise;
  assign cycles_inc  = (frame_cycles == CNT_MAX) ? frame_cycles : frame_cycles + CNT_W'(1);

  always_comb begin
    state_n     = state;
    sticky_n    = sticky;
    cycles_n    = frame_cycles;
    timed_out_n = timed_out;
    case (state)
      S_IDLE: begin
        if (start_rise) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        sticky_n    = '0;
        cycles_n    = '0;
        timed_out_n = 1'b0;
        state_n     = S_RUN;
      end
      S_RUN: begin
        sticky_n = sticky_next;
        cycles_n = cycles_inc;
        if (&sticky_next) begin
          state_n = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cycles_inc == TIMEOUT_VAL)) begin
          state_n     = S_DONE;
          timed_out_n = 1'b1;
        end
      end
      S_DONE: begin
        if (start_rise) state_n = S_LAUNCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // start_d resets high so a start held through reset needs a fresh 0->1 edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      start_d      <= 1'b1;
      done_d       <= '0;
      sticky       <= '0;
      frame_cycles <= '0;
      timed_out    <= 1'b0;
    end else begin
      state        <= state_n;
      start_d      <= start;
      done_d       <= solver_done;
      sticky       <= sticky_n;
      frame_cycles <= cycles_n;
      timed_out    <= timed_out_n;
    end
  end

  assign solver_start = (state == S_LAUNCH);
  assign busy         = (state == S_LAUNCH) || (state == S_RUN);
  assign all_done     = (state == S_DONE);

endmodule

// File: tb/tb_mandel_frame_done_collector.sv
// Directed bench for mandel_frame_done_collector: a frame-level reference model checked every cycle
// plus literal expectations at key points of each scenario.
module tb_mandel_frame_done_collector;

  localparam int NS  = 8;
  localparam int TO  = 20;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [NS-1:0] solver_done;
  logic          solver_start, busy, all_done, timed_out;
  logic [CW-1:0] frame_cycles;

  int errors = 0;
  int checks = 0;
  int launches = 0;

  mandel_frame_done_collector #(
    .NUM_SOLVERS(NS), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .solver_done(solver_done),
    .solver_start(solver_start), .busy(busy), .all_done(all_done),
    .timed_out(timed_out), .frame_cycles(frame_cycles)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: frame phase 0=idle 1=launch 2=run 3=done
  int          m_phase;
  bit [NS-1:0] m_seen;
  longint      m_cycles;
  bit          m_to;
  bit          m_prev_start;
  bit [NS-1:0] m_prev_done;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase = 0; m_seen = '0; m_cycles = 0; m_to = 0;
      m_prev_start = 1; m_prev_done = '0;
    end else begin
      bit          new_req;
      bit [NS-1:0] fresh;
      new_req = start && !m_prev_start;
      fresh   = solver_done & ~m_prev_done;
      if (m_phase == 0 || m_phase == 3) begin
        if (new_req) m_phase = 1;
      end else if (m_phase == 1) begin
        m_seen = '0; m_cycles = 0; m_to = 0; m_phase = 2;
      end else begin
        int n;
        m_seen = m_seen | fresh;
        if (m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
        n = 0;
        for (int i = 0; i < NS; i++) if (m_seen[i]) n++;
        if (n == NS) m_phase = 3;
        else if (m_cycles == TO) begin m_phase = 3; m_to = 1; end
      end
      m_prev_start = start;
      m_prev_done  = solver_done;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare process, 1 time unit after each active edge
  always @(posedge clk) begin
    #1;
    if (solver_start) launches++;
    check("solver_start", solver_start, m_phase == 1);
    check("busy", busy, m_phase == 1 || m_phase == 2);
    check("all_done", all_done, m_phase == 3);
    check("timed_out", timed_out, m_to);
    check("frame_cycles", frame_cycles, m_cycles);
  end

  // driver: inputs change on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b0; tick();
    start = 1'b1; tick();  // now in LAUNCH
  endtask

  initial begin
    int l0;
    reset_n = 1'b0; start = 1'b1; solver_done = '0;
    repeat (10) tick();
    check("rst_all_done", all_done, 0);
    check("rst_frame_cycles", frame_cycles, 0);
    reset_n = 1'b1;
    repeat (5) tick();
    check("held_start_no_launch", launches, 0);
    check("held_start_busy", busy, 0);

    // frame 1: done bits rise one per cycle on RUN cycles 5..12
    l0 = launches;
    pulse_start();
    check("f1_solver_start", solver_start, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 5) solver_done[k-5] = 1'b1;
    end
    tick();
    check("f1_all_done", all_done, 1);
    check("f1_frame_cycles", frame_cycles, 12);
    check("f1_timed_out", timed_out, 0);
    check("f1_one_pulse", launches - l0, 1);

    // frame 2: restart from DONE, all bits together on RUN cycle 3, second start edge ignored
    l0 = launches;
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("f2_all_done_fell", all_done, 0);
    solver_done = '0;
    tick();                    // RUN 1
    start = 1'b0; tick();      // RUN 2
    start = 1'b1; tick();      // RUN 3, ignored edge
    solver_done = '1;
    tick();
    check("f2_all_done", all_done, 1);
    check("f2_frame_cycles", frame_cycles, 3);
    check("f2_one_pulse", launches - l0, 1);

    // frame 3: timeout; bit 0 rises during LAUNCH (not captured), bit 1 pulses twice, bit 7 never
    solver_done = '0; tick(); tick();
    pulse_start();
    solver_done[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k >= 2 && k <= 7) solver_done[k-1] = 1'b1;
      if (k == 9) solver_done[1] = 1'b0;
      if (k == 10) solver_done[1] = 1'b1;
    end
    tick();
    check("f3_all_done", all_done, 1);
    check("f3_timed_out", timed_out, 1);
    check("f3_frame_cycles", frame_cycles, 20);

    // frame 4: completion on RUN cycle 20 coincides with timeout, completion wins
    solver_done = '0; tick();
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 20) solver_done = '1;
    end
    tick();
    check("f4_all_done", all_done, 1);
    check("f4_timed_out", timed_out, 0);
    check("f4_frame_cycles", frame_cycles, 20);

    // reset mid-RUN, then a normal frame
    solver_done = '0; tick();
    pulse_start();
    repeat (4) tick();
    check("f5_busy_before_reset", busy, 1);
    reset_n = 1'b0; tick();
    check("f5_reset_busy", busy, 0);
    check("f5_reset_frame_cycles", frame_cycles, 0);
    reset_n = 1'b1; tick(); tick();
    check("f5_no_launch_after_reset", busy, 0);
    pulse_start();
    tick(); tick();            // RUN 2
    solver_done = '1;
    tick();
    check("f6_all_done", all_done, 1);
    check("f6_frame_cycles", frame_cycles, 2);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
